instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of MainDecode and ProgramCounter in the RV32EC multi-cycle core.
- Issues 32-bit word reads to instruction memory and buffers the returned halfwords.
- Realigns mixed 16/32-bit (RVC) instruction streams and presents one complete instruction at a time to decode, with its address and a compressed flag.
- Handles PC redirects (branch/jump) by flushing the buffer and discarding in-flight stale data.

Parameters:
- RESET_VECTOR, 32'h0000_0000, fetch address loaded on reset (bit 0 forced to 0).
- MEM_ADDR_W, 32, width of MemAddr.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset)
- MemReq  output  1  word read request valid
- MemAddr  output  MEM_ADDR_W  word-aligned request address, [1:0]=00
- MemReady  input  1  memory accepts request this cycle
- MemRspValid  input  1  read data valid
- MemRspData  input  32  read word; [15:0] = lower-address halfword
- RedirectValid  input  1  core requests new fetch PC
- RedirectAddr  input  32  new PC; bit 0 ignored
- InstValid  output  1  Instruction holds a complete instruction
- InstReady  input  1  decode consumes the instruction this cycle
- Instruction  output  32  instruction; [31:16]=0 when compressed
- InstAddr  output  32  address of Instruction
- InstCompressed  output  1  Instruction is 16-bit ([1:0]!=2'b11)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, buffer count=0, FetchPC=RESET_VECTOR, DecodePC=RESET_VECTOR.
  - MemReq=0, InstValid=0, Instruction=0, InstAddr=RESET_VECTOR, InstCompressed=0.
- Buffer: 4 halfword entries (64 bits), count 0..4, entry 0 = oldest; DecodePC = address of entry 0.
- FSM states:
  - IDLE: go to REQ when count<=2 and no redirect.
  - REQ: MemReq=1, MemAddr={FetchPC[31:2],2'b00}; on MemReady go to WAIT.
  - WAIT: on MemRspValid, append 2 halfwords (1 if drop-low is set), FetchPC+=4, go to IDLE. With count<=2 after the append and same-cycle consume permitting, go straight to REQ.
  - FLUSH: a request is outstanding after a redirect; the next MemRspValid is discarded, then go to REQ.
- Single outstanding request. MemRspValid outside WAIT/FLUSH is ignored.
- MemReq/MemAddr are held stable until MemReady; a request is never withdrawn except by redirect or reset.
- Instruction completeness:
  - count>=1 and entry0[1:0]!=11 gives a compressed instruction, valid.
  - count>=2 and entry0[1:0]==11 gives a 32-bit instruction {entry1,entry0}, valid.
  - Otherwise InstValid=0.
- Outputs are registered-state driven (no combinational path from Mem* to Inst*, except under IFU_BYPASS_EN).
- Consume (InstValid & InstReady): pop 1 or 2 entries; DecodePC += 2 or 4, wrapping modulo 2^32.
- Append and pop in the same cycle are legal; the count update is net.
- Redirect (RedirectValid=1), which has priority over consume and append:
  - Clear buffer; DecodePC={RedirectAddr[31:1],1'b0}; FetchPC={RedirectAddr[31:2],2'b00}; drop-low=RedirectAddr[1].
  - State in IDLE or WAIT-with-response-this-cycle: go to REQ.
  - State in REQ with MemReady=0: update MemAddr next cycle (stay REQ).
  - State in REQ with MemReady=1, or in WAIT without response: go to FLUSH.
  - A response in the same cycle as a redirect is dropped.
  - InstValid=0 the cycle after a redirect.
- Drop-low: the first response after a redirect to a halfword-aligned address (bit1=1) appends only [31:16].
- 32-bit instruction straddling a word boundary: the upper half comes from the next response; InstValid stays 0 until it arrives.
- Reset mid-transaction: returns to IDLE at once. Memory is reset together, so a late response is never accepted (ignored outside WAIT/FLUSH).

Optional Feature:
- IFU_BYPASS_EN defined: when count==0, state WAIT, and MemRspValid=1, Instruction/InstValid/InstCompressed are driven combinationally from MemRspData (honouring drop-low). A compressed or in-word 32-bit instruction is valid the same cycle. Consume that cycle pops from the incoming data; the rest is buffered.
- Undefined: the earliest InstValid is one cycle after MemRspValid.

Test Plan:
- Reset, RESET_VECTOR=0, memory word0=32'h00A0_0513 (addi a0,x0,10), zero-latency ready -> MemReq=1 with MemAddr=0 after reset release; InstValid=1, Instruction=32'h00A00513, InstAddr=0, InstCompressed=0 (bypass off: 1 cycle after response).
- Word0=32'h4501_4505 (c.li a0,1; c.li a0,0), InstReady=1 -> two instructions: 16'h4505 @0 then 16'h4501 @2, InstCompressed=1, upper bits zero.
- Word0=32'h0513_4505, word1=32'h0000_00A0 -> c.li @0, then 32'h00A00513 @2 valid only after word1 arrives.
- Redirect to 32'h0000_0106 while WAIT outstanding -> outstanding response discarded, next MemAddr=32'h104, low half dropped, first InstAddr=32'h106.
- InstReady=0 held for 10 cycles -> buffer fills to count 3–4, no more than one request beyond count<=2, no data lost; release gives in-order stream.
- rst=0 asserted during WAIT, then released -> all outputs at reset values, MemAddr=RESET_VECTOR, the stale MemRspValid pulse is ignored.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32EC fetch stage with a 4-halfword realignment buffer for mixed 16/32-bit streams.
// Define IFU_BYPASS_EN to forward response data straight to decode when the buffer is empty.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  MemReq,
  output logic [MEM_ADDR_W-1:0] MemAddr,
  input  logic                  MemReady,
  input  logic                  MemRspValid,
  input  logic [31:0]           MemRspData,
  input  logic                  RedirectValid,
  input  logic [31:0]           RedirectAddr,
  output logic                  InstValid,
  input  logic                  InstReady,
  output logic [31:0]           Instruction,
  output logic [31:0]           InstAddr,
  output logic                  InstCompressed
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;
  state_t      r_state;
  logic [15:0] r_buf [4];
  logic [2:0]  r_count;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_decode_pc;
  logic        r_drop_low;
  logic        w_rsp;
  logic [2:0]  w_app_n;
  logic [2:0]  w_pop;
  logic [2:0]  w_vcount;
  logic [2:0]  w_cnext;
  logic [15:0] w_merge [4];
  logic [15:0] w_next [4];
  logic [15:0] w_v0;
  logic [15:0] w_v1;
  logic        w_is32;
  logic        w_valid;
  assign w_rsp   = (r_state == WAIT) && MemRspValid && !RedirectValid;
  assign w_app_n = !w_rsp ? 3'd0 : r_drop_low ? 3'd1 : 3'd2;
  // buffer contents with this cycle's response appended behind the live entries
  always_comb begin
    for (int i = 0; i < 4; i++)
      w_merge[i] = (w_rsp && 3'(i) == r_count) ? (r_drop_low ? MemRspData[31:16] : MemRspData[15:0]) :
                   (w_rsp && !r_drop_low && 3'(i) == r_count + 3'd1) ? MemRspData[31:16] : r_buf[i];
  end
`ifdef IFU_BYPASS_EN
  assign w_v0     = w_merge[0];
  assign w_v1     = w_merge[1];
  assign w_vcount = (r_count == 3'd0) ? w_app_n : r_count;
`else
  assign w_v0     = r_buf[0];
  assign w_v1     = r_buf[1];
  assign w_vcount = r_count;
`endif
  assign w_is32  = w_v0[1:0] == 2'b11;
  assign w_valid = w_vcount >= (w_is32 ? 3'd2 : 3'd1);
  assign w_pop   = (w_valid && InstReady && !RedirectValid) ? (w_is32 ? 3'd2 : 3'd1) : 3'd0;
  assign w_cnext = r_count + w_app_n - w_pop;
  always_comb begin
    for (int i = 0; i < 4; i++)
      w_next[i] = (3'(i) + w_pop < 3'd4) ? w_merge[2'(3'(i) + w_pop)] : 16'h0;
  end
  assign MemReq         = r_state == REQ;
  assign MemAddr        = MEM_ADDR_W'(r_fetch_pc & 32'hFFFF_FFFC);
  assign InstValid      = w_valid;
  assign Instruction    = !w_valid ? 32'h0 : w_is32 ? {w_v1, w_v0} : {16'h0, w_v0};
  assign InstAddr       = r_decode_pc;
  assign InstCompressed = w_valid && !w_is32;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_buf       <= '{default: 16'h0};
      r_count     <= 3'd0;
      r_fetch_pc  <= RESET_VECTOR & 32'hFFFF_FFFC;
      r_decode_pc <= RESET_VECTOR & 32'hFFFF_FFFE;
      r_drop_low  <= RESET_VECTOR[1];
    end else if (RedirectValid) begin
      r_buf       <= '{default: 16'h0};
      r_count     <= 3'd0;
      r_fetch_pc  <= RedirectAddr & 32'hFFFF_FFFC;
      r_decode_pc <= RedirectAddr & 32'hFFFF_FFFE;
      r_drop_low  <= RedirectAddr[1];
      // a request already accepted but not yet answered leaves a stale response to discard
      r_state     <= ((r_state == REQ && MemReady) || ((r_state == WAIT || r_state == FLUSH) && !MemRspValid)) ? FLUSH : REQ;
    end else begin
      r_buf       <= w_next;
      r_count     <= w_cnext;
      r_decode_pc <= r_decode_pc + {28'h0, w_pop, 1'b0};
      if (w_rsp) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_drop_low <= 1'b0;
      end
      case (r_state)
        IDLE:    r_state <= (r_count <= 3'd2) ? REQ : IDLE;
        REQ:     r_state <= MemReady ? WAIT : REQ;
        WAIT:    r_state <= !MemRspValid ? WAIT : (w_cnext <= 3'd2) ? REQ : IDLE;
        default: r_state <= MemRspValid ? REQ : FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, RVC realignment, redirect, backpressure and reset.
module tb_instruction_fetch_unit;
  logic        clk;
  logic        rst;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemReady;
  logic        MemRspValid = 1'b0;
  logic [31:0] MemRspData = 32'h0;
  logic        RedirectValid;
  logic [31:0] RedirectAddr;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] Instruction;
  logic [31:0] InstAddr;
  logic        InstCompressed;
  logic [31:0] mem [128];
  int          n_assert;
  int          n_fail;
  int          lat;
  int          acc_cnt = 0;
  int          cnt = 0;
  bit          pend = 1'b0;
  bit          inject;
  logic [31:0] paddr = 32'h0;

  instruction_fetch_unit #(.RESET_VECTOR(32'h0), .MEM_ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .MemReq(MemReq), .MemAddr(MemAddr), .MemReady(MemReady),
    .MemRspValid(MemRspValid), .MemRspData(MemRspData), .RedirectValid(RedirectValid),
    .RedirectAddr(RedirectAddr), .InstValid(InstValid), .InstReady(InstReady),
    .Instruction(Instruction), .InstAddr(InstAddr), .InstCompressed(InstCompressed));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory: accepts on MemReq&MemReady, answers lat cycles later; reset together with the core
  always @(negedge clk) begin
    MemRspValid = 1'b0;
    if (!rst) pend = 1'b0;
    if (inject) begin
      MemRspValid = 1'b1;
      MemRspData  = 32'h00A00513;
    end else if (pend) begin
      if (cnt == 0) begin
        MemRspValid = 1'b1;
        MemRspData  = mem[paddr[8:2]];
        pend        = 1'b0;
      end else cnt--;
    end
    if (rst && MemReq && MemReady) begin
      pend  = 1'b1;
      paddr = MemAddr;
      cnt   = lat - 1;
      acc_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 128; i++) mem[i] = 32'h00010001;
  endtask

  task automatic start();
    rst = 1'b0; InstReady = 1'b0; RedirectValid = 1'b0; RedirectAddr = 32'h0;
    MemReady = 1'b1; lat = 1; inject = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++)
      if (InstValid === 1'b1) ok = 1'b1; else step();
  endtask

  task automatic test_reset();
    fill();
    mem[0] = 32'h00A00513;
    rst = 1'b0; InstReady = 1'b0; RedirectValid = 1'b0; RedirectAddr = 32'h0;
    MemReady = 1'b1; lat = 1; inject = 1'b0;
    step(); step();
    n_assert++;
    if (MemReq !== 1'b0 || InstValid !== 1'b0 || InstCompressed !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: MemReq=%b InstValid=%b InstCompressed=%b, expected 0 0 0", MemReq, InstValid, InstCompressed);
    end
    n_assert++;
    if (Instruction !== 32'h0 || InstAddr !== 32'h0 || MemAddr !== 32'h0) begin
      n_fail++; $display("FAIL reset_values: Instruction=%h InstAddr=%h MemAddr=%h, expected all 00000000", Instruction, InstAddr, MemAddr);
    end
    rst = 1'b1;
    step();
    n_assert++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: MemReq=%b MemAddr=%h, expected 1 00000000", MemReq, MemAddr);
    end
    step();
    n_assert++;
    if (InstValid !== 1'b0) begin
      n_fail++; $display("FAIL no_early_valid: InstValid=%b, expected 0", InstValid);
    end
    step();
    n_assert++;
    if (InstValid !== 1'b1 || Instruction !== 32'h00A00513 || InstAddr !== 32'h0 || InstCompressed !== 1'b0) begin
      n_fail++; $display("FAIL first_inst: valid=%b instr=%h addr=%h c=%b, expected 1 00a00513 @00000000 c=0", InstValid, Instruction, InstAddr, InstCompressed);
    end
  endtask

  task automatic test_compressed();
    bit ok;
    fill();
    mem[0] = 32'h45014505;
    start();
    InstReady = 1'b1;
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00004505 || InstAddr !== 32'h0 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL rvc_first: valid=%b instr=%h addr=%h c=%b, expected 00004505 @00000000 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
    step();
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00004501 || InstAddr !== 32'h2 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL rvc_second: valid=%b instr=%h addr=%h c=%b, expected 00004501 @00000002 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
    step();
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00000001 || InstAddr !== 32'h4 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL rvc_third: valid=%b instr=%h addr=%h c=%b, expected 00000001 @00000004 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
  endtask

  task automatic test_straddle();
    bit ok;
    fill();
    mem[0] = 32'h05134505;
    mem[1] = 32'h000000A0;
    start();
    InstReady = 1'b1;
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00004505 || InstAddr !== 32'h0 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL straddle_rvc: valid=%b instr=%h addr=%h c=%b, expected 00004505 @00000000 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
    step();
    n_assert++;
    if (InstValid !== 1'b0) begin
      n_fail++; $display("FAIL straddle_half: InstValid=%b, expected 0 while upper half missing", InstValid);
    end
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00A00513 || InstAddr !== 32'h2 || InstCompressed !== 1'b0) begin
      n_fail++; $display("FAIL straddle_32: valid=%b instr=%h addr=%h c=%b, expected 00a00513 @00000002 c=0", InstValid, Instruction, InstAddr, InstCompressed);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    fill();
    mem[0]    = 32'h00A00513;
    mem[8'h41] = 32'h45050001;
    start();
    lat = 2;
    step(); step();
    RedirectValid = 1'b1; RedirectAddr = 32'h00000106;
    step();
    RedirectValid = 1'b0;
    n_assert++;
    if (InstValid !== 1'b0 || MemReq !== 1'b0) begin
      n_fail++; $display("FAIL redirect_flush: InstValid=%b MemReq=%b, expected 0 0", InstValid, MemReq);
    end
    step();
    n_assert++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h104) begin
      n_fail++; $display("FAIL redirect_addr: MemReq=%b MemAddr=%h, expected 1 00000104", MemReq, MemAddr);
    end
    InstReady = 1'b1;
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00004505 || InstAddr !== 32'h106 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL redirect_first: valid=%b instr=%h addr=%h c=%b, expected 00004505 @00000106 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
    step();
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00000001 || InstAddr !== 32'h108 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL redirect_next: valid=%b instr=%h addr=%h c=%b, expected 00000001 @00000108 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
  endtask

  task automatic test_redirect_req();
    bit ok;
    fill();
    mem[8] = 32'h00A00513;
    start();
    MemReady = 1'b0;
    step();
    RedirectValid = 1'b1; RedirectAddr = 32'h00000020;
    step();
    RedirectValid = 1'b0;
    n_assert++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h20) begin
      n_fail++; $display("FAIL redirect_req_addr: MemReq=%b MemAddr=%h, expected 1 00000020", MemReq, MemAddr);
    end
    MemReady = 1'b1;
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00A00513 || InstAddr !== 32'h20 || InstCompressed !== 1'b0) begin
      n_fail++; $display("FAIL redirect_req_inst: valid=%b instr=%h addr=%h c=%b, expected 00a00513 @00000020 c=0", InstValid, Instruction, InstAddr, InstCompressed);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc0;
    logic [15:0] h;
    fill();
    for (int i = 0; i < 4; i++) mem[i] = {16'h4001 + 16'((2 * i + 1) * 4), 16'h4001 + 16'(2 * i * 4)};
    start();
    acc0 = acc_cnt;
    for (int i = 0; i < 10; i++) step();
    n_assert++;
    if (acc_cnt - acc0 !== 2 || MemReq !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_reqs: accepted=%0d MemReq=%b, expected 2 0", acc_cnt - acc0, MemReq);
    end
    InstReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      h = 16'h4001 + 16'(k * 4);
      wait_valid(ok);
      n_assert++;
      if (!ok || Instruction !== {16'h0, h} || InstAddr !== 32'(2 * k) || InstCompressed !== 1'b1) begin
        n_fail++; $display("FAIL backpressure_stream[%0d]: valid=%b instr=%h addr=%h c=%b, expected %h @%h c=1", k, InstValid, Instruction, InstAddr, InstCompressed, {16'h0, h}, 32'(2 * k));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill();
    mem[0] = 32'h45014505;
    start();
    lat = 3;
    step(); step();
    rst = 1'b0;
    step();
    n_assert++;
    if (MemReq !== 1'b0 || InstValid !== 1'b0 || InstAddr !== 32'h0 || MemAddr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_values: MemReq=%b InstValid=%b InstAddr=%h MemAddr=%h, expected 0 0 00000000 00000000", MemReq, InstValid, InstAddr, MemAddr);
    end
    rst = 1'b1;
    inject = 1'b1;
    step();
    inject = 1'b0;
    lat = 1;
    n_assert++;
    if (InstValid !== 1'b0 || MemReq !== 1'b1 || MemAddr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_stale: InstValid=%b MemReq=%b MemAddr=%h, expected 0 1 00000000", InstValid, MemReq, MemAddr);
    end
    InstReady = 1'b1;
    wait_valid(ok);
    n_assert++;
    if (!ok || Instruction !== 32'h00004505 || InstAddr !== 32'h0 || InstCompressed !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_inst: valid=%b instr=%h addr=%h c=%b, expected 00004505 @00000000 c=1", InstValid, Instruction, InstAddr, InstCompressed);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0; InstReady = 1'b0; RedirectValid = 1'b0; RedirectAddr = 32'h0;
    MemReady = 1'b1; lat = 1; inject = 1'b0;
    test_reset();
    test_compressed();
    test_straddle();
    test_redirect();
    test_redirect_req();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
